// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encodings,
// default widths and the {HI, LO} field positions inside the result word.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } divState_e;

    localparam int LO_LSB = 0;
    localparam int LO_MSB = DIV_WIDTH - 1;
    localparam int HI_LSB = DIV_WIDTH;
    localparam int HI_MSB = 2 * DIV_WIDTH - 1;

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Stalls the pipeline while busy and returns {remainder, quotient} for HI/LO.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    divState_e            state, nextState;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     dvdQuo;   // dividend bits shift out the top as quotient bits shift in
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     partRem;
    logic                 signQ, signR;
    logic [2*WIDTH-1:0]   resultReg;

    logic                 accept;
    logic                 lastIter;
    logic [WIDTH-1:0]     absA, absB;
    logic [WIDTH:0]       shifted, trial;
    logic [WIDTH-1:0]     stepRem, stepQuo, quoFix, remFix;

    assign accept   = start_i & ~annul_i;
    assign lastIter = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        absA    = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        absB    = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted = {partRem, dvdQuo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        stepRem = shifted[WIDTH-1:0];
        stepQuo = {dvdQuo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            stepRem = trial[WIDTH-1:0];
            stepQuo = {dvdQuo[WIDTH-2:0], 1'b1};
        end
        quoFix = signQ ? -stepQuo : stepQuo;
        remFix = signR ? -stepRem : stepRem;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (annul_i) begin
            nextState = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start_i) nextState = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
                DIV_ZERO: nextState = DIV_END;
                DIV_ON:   if (lastIter) nextState = DIV_END;
                DIV_END:  nextState = DIV_IDLE;
                default:  nextState = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o  = accept & (state != DIV_END);
        ready_o  = (state == DIV_END) & ~annul_i;
        result_o = resultReg;
    end

    // The result is captured on entry to END so it is valid during the ready
    // cycle and holds afterwards until the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            dvdQuo    <= '0;
            divisor   <= '0;
            partRem   <= '0;
            signQ     <= 1'b0;
            signR     <= 1'b0;
            resultReg <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept && opdata2_i != '0) begin
                        cnt     <= '0;
                        dvdQuo  <= absA;
                        divisor <= absB;
                        partRem <= '0;
                        signQ   <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        signR   <= signed_i & opdata1_i[WIDTH-1];
                    end
                end
                DIV_ON: begin
                    partRem <= stepRem;
                    dvdQuo  <= stepQuo;
                    cnt     <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (nextState == DIV_END) begin
                resultReg <= (state == DIV_ZERO) ? '0 : {remFix, quoFix};
            end
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: a vector table of DIV/DIVU cases plus
// hand-written annul, back-to-back and mid-operation reset sequences.
module tb_div_radix2;
    import div_radix2_pkg::*;

    localparam int W = DIV_WIDTH;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic             sgn;
    logic [W-1:0]     op1, op2;
    logic             annul;
    logic             stall, ready;
    logic [2*W-1:0]   result;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs [13];

    div_radix2 dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start),
        .signed_i  (sgn),
        .opdata1_i (op1),
        .opdata2_i (op2),
        .annul_i   (annul),
        .stall_o   (stall),
        .ready_o   (ready),
        .result_o  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Start one divide at the next falling edge (cycle 0), scramble operands
    // once it is running, drop start after the ready cycle and check timing.
    task automatic runDiv(input vec_t v, input string name);
        int stallCnt = 0;
        int readyAt  = -1;
        int expLat;
        logic [2*W-1:0] got = '0;
        expLat = (v.b == '0) ? 2 : W + 1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b1;
        sgn   = v.sgn;
        op1   = v.a;
        op2   = v.b;
        for (int c = 0; c < 100 && readyAt < 0; c++) begin
            #1;
            if (stall) stallCnt++;
            if (ready) begin
                readyAt = c;
                got     = result;
            end
            @(negedge clk);
            if (readyAt >= 0) begin
                start = 1'b0;
            end else begin
                op1 = $urandom;
                op2 = $urandom;
                sgn = ~sgn;
            end
        end
        #1;
        check({name, " ready cycle"}, 64'(readyAt), 64'(expLat));
        check({name, " stall cycles"}, 64'(stallCnt), 64'(expLat));
        check({name, " result"}, got, {v.r, v.q});
        check({name, " ready single pulse"}, 64'(ready), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int stallCnt;
        int r1, r2, nReady;
        logic [2*W-1:0] res1, res2;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'h00000000, 32'h00000000};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{1'b0, 32'd7,          32'd100,        32'h00000000, 32'h00000007};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'h00000000};
        vecs[10] = '{1'b0, 32'h80000000,   32'h00000003,   32'h2AAAAAAA, 32'h00000002};
        vecs[11] = '{1'b1, 32'h80000000,   32'h00000002,   32'hC0000000, 32'h00000000};
        vecs[12] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001};

        resetn = 1'b0;
        start  = 1'b0;
        sgn    = 1'b0;
        annul  = 1'b0;
        op1    = '0;
        op2    = '0;
        #1;
        check("reset ready", 64'(ready), 64'(0));
        check("reset stall", 64'(stall), 64'(0));
        check("reset result", result, '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            runDiv(vecs[i], $sformatf("vec%0d", i));
        end

        // Annul at cycle 10 of a running DIVU, then a fresh DIVU 9 / 3.
        early    = 0;
        stallCnt = 0;
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        op1   = 32'd1000;
        op2   = 32'd3;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ready) early++;
            if (stall) stallCnt++;
            @(negedge clk);
        end
        annul = 1'b1;
        #1;
        check("annul stall drop", 64'(stall), 64'(0));
        check("annul ready low", 64'(ready), 64'(0));
        check("annul no early ready", 64'(early), 64'(0));
        check("annul stall before", 64'(stallCnt), 64'(10));
        runDiv('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0}, "after annul");

        // Back-to-back DIVUs: start stays high across the END cycle.
        r1     = -1;
        r2     = -1;
        nReady = 0;
        res1   = '0;
        res2   = '0;
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        op1   = 32'd100;
        op2   = 32'd7;
        for (int c = 0; c < 120; c++) begin
            #1;
            if (ready) begin
                nReady++;
                if (r1 < 0) begin
                    r1   = c;
                    res1 = result;
                end else begin
                    r2   = c;
                    res2 = result;
                end
            end
            @(negedge clk);
            if (r2 >= 0) begin
                start = 1'b0;
            end else if (r1 >= 0 && c == r1) begin
                op1 = 32'd50;
                op2 = 32'd5;
            end
        end
        check("b2b ready count", 64'(nReady), 64'(2));
        check("b2b first ready", 64'(r1), 64'(33));
        check("b2b spacing", 64'(r2 - r1), 64'(34));
        check("b2b first result", res1, {32'h2, 32'hE});
        check("b2b second result", res2, {32'h0, 32'hA});

        // Asynchronous reset in the middle of an ON sequence.
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        op1   = 32'd100;
        op2   = 32'd7;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("midreset ready", 64'(ready), 64'(0));
        check("midreset stall", 64'(stall), 64'(0));
        check("midreset result", result, '0);
        @(negedge clk);
        resetn = 1'b1;
        nReady = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready) nReady++;
            @(negedge clk);
        end
        check("post reset no ready", 64'(nReady), 64'(0));
        check("post reset result", result, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the execute stage. Executes DIV and DIVU.
- Drives stall_divE into the hazard unit while busy; the hazard unit uses it to stall F/D/E and flush M.
- Delivers {remainder, quotient} for the HI/LO write.
- Accepts the exception flush as an annul, so a divide behind a faulting memory-stage instruction is discarded.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  pipeline clock; rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  EX holds a DIV/DIVU. Held high by the pipeline while stall_o is high.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend (rs value after forwarding).
- opdata2_i  in  WIDTH  divisor (rt value after forwarding).
- annul_i  in  1  exception flush (flush_except); aborts any operation.
- stall_o  out  1  to hazard unit as stall_divE.
- ready_o  out  1  result valid this cycle.
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}, i.e. {HI, LO}.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; cnt = 0; all datapath registers = 0.
  - ready_o = 0; result_o = 0; stall_o = 0.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - If start_i & ~annul_i and opdata2_i == 0: go to DIVZERO.
  - Else if start_i & ~annul_i: go to ON, with cnt = 0. Latch |dividend| and |divisor| (absolute values when signed_i = 1, raw values otherwise). Latch sign_q = signed_i & (op1[31] ^ op2[31]) and sign_r = signed_i & op1[31].
  - Otherwise stay in IDLE.
- DIVZERO: one cycle, then go to END with quotient = 0 and remainder = 0. Divide-by-zero is architecturally UNPREDICTABLE; 0 is our fixed choice.
- ON: one restoring iteration per cycle.
  - Shift partial remainder left by 1, bringing in the next dividend MSB.
  - Compute trial = partial - divisor as a (WIDTH+1)-bit subtraction.
  - If trial is non-negative: keep trial and shift in quotient bit 1. Otherwise keep partial and shift in 0.
  - cnt increments each cycle. When cnt == WIDTH-1 the final iteration completes and the state goes to END.
- END:
  - ready_o = 1 for exactly this one cycle.
  - result_o: quotient negated if sign_q; remainder negated if sign_r. Negation is two's complement in WIDTH bits.
  - Then go to IDLE unconditionally, regardless of start_i.
- result_o holds its END value until the next END or reset. It is consumed only when ready_o = 1.
- stall_o = start_i & ~annul_i & (state != END). This is combinational, so it is asserted in the same cycle the divide arrives in IDLE.
- Latency for a nonzero divisor, with start seen in IDLE at cycle t:
  - ON occupies t+1 .. t+WIDTH.
  - END occurs at t+WIDTH+1.
  - stall_o is high for cycles t .. t+WIDTH (33 cycles at default).
- Latency for a zero divisor: DIVZERO at t+1, END at t+2, stall_o high for cycles t .. t+1.
- Annul: annul_i = 1 in any state forces state = IDLE next cycle, with ready_o = 0 and stall_o = 0 immediately. The partial result is discarded.
- Back-to-back divides:
  - The pipeline advances on the END cycle.
  - The next cycle is IDLE, so a following DIV in EX starts there. It is never merged with the previous operation.
- Corner cases:
  - Operands change while in ON: ignored, because they were latched at start.
  - Signed overflow case 0x80000000 / 0xFFFFFFFF: the absolute-value path gives quotient 0x80000000 and remainder 0.

Decomposition:
- Shared defines header: state encodings (DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END), DIV_WIDTH = 32, and the result field bit ranges for HI/LO.
- No sub-module. The iteration step is a single always block; the sign-fix negation is inline.

Test Plan:
- DIVU 100 / 7, start at cycle 0:
  - stall_o high for cycles 0–32.
  - ready_o high at cycle 33 only.
  - result_o = {0x00000002, 0x0000000E}.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 7 / -2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide-by-zero, 5 / 0 (DIV and DIVU):
  - stall_o high for 2 cycles.
  - ready_o at cycle 2.
  - result_o = 0.
- Annul at cycle 10 of an ON sequence:
  - stall_o drops at cycle 10.
  - ready_o never asserts.
  - state is IDLE at cycle 11.
  - A new DIVU 9 / 3 then completes with quotient 3, remainder 0.
- Two consecutive DIVUs (100 / 7, then 50 / 5):
  - Two separate ready pulses 34 cycles apart.
  - Second result = {0, 0x0000000A}.
- resetn pulsed low mid-ON:
  - Outputs go to 0 asynchronously.
  - After release with start_i low, no ready_o appears.
